// File: rtl/e_muldiv.sv
// E-stage multiply/divide unit: multi-cycle MULT/DIV with HI/LO registers.
// MTHI/MTLO writes and MFHI/MFLO read path are single-cycle.
module e_muldiv #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Req,
   input  logic [2:0]  mdOp,
   input  logic        rdSel,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] muldivRes_E
);

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW      = ($clog2(MAX_CYC + 1) > 4) ? $clog2(MAX_CYC + 1) : 4;

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_op;
   logic [31:0]   r_a;
   logic [31:0]   r_b;
   logic [31:0]   r_hi;
   logic [31:0]   r_lo;

   logic          w_start_op;
   logic          w_mul_sgn;
   logic [63:0]   w_ma;
   logic [63:0]   w_mb;
   logic [63:0]   w_prod;
   logic          w_a_neg;
   logic          w_b_neg;
   logic [31:0]   w_a_mag;
   logic [31:0]   w_b_mag;
   logic [31:0]   w_b_safe;
   logic [31:0]   w_q_mag;
   logic [31:0]   w_r_mag;
   logic [31:0]   w_quot;
   logic [31:0]   w_rem;

   assign w_start_op = (mdOp >= OP_MULT) && (mdOp <= OP_DIVU);

   assign w_mul_sgn = (r_op == OP_MULT);
   assign w_ma      = {{32{w_mul_sgn & r_a[31]}}, r_a};
   assign w_mb      = {{32{w_mul_sgn & r_b[31]}}, r_b};
   assign w_prod    = w_ma * w_mb;

   // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000
   assign w_a_neg  = (r_op == OP_DIV) & r_a[31];
   assign w_b_neg  = (r_op == OP_DIV) & r_b[31];
   assign w_a_mag  = w_a_neg ? (32'd0 - r_a) : r_a;
   assign w_b_mag  = w_b_neg ? (32'd0 - r_b) : r_b;
   assign w_b_safe = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
   assign w_q_mag  = w_a_mag / w_b_safe;
   assign w_r_mag  = w_a_mag % w_b_safe;
   assign w_quot   = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
   assign w_rem    = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

   assign busy        = (r_state == ST_BUSY) | (w_start_op & ~Req);
   assign HI          = r_hi;
   assign LO          = r_lo;
   assign muldivRes_E = rdSel ? r_hi : r_lo;

   // Control FSM, operand latches and HI/LO update
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_op    <= 3'd0;
         r_a     <= 32'd0;
         r_b     <= 32'd0;
         r_hi    <= 32'd0;
         r_lo    <= 32'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!Req) begin
                  case (mdOp)
                     OP_MULT, OP_MULTU: begin
                        r_op    <= mdOp;
                        r_a     <= A;
                        r_b     <= B;
                        r_cnt   <= CW'(MULT_CYCLES);
                        r_state <= ST_BUSY;
                     end
                     OP_DIV, OP_DIVU: begin
                        r_op    <= mdOp;
                        r_a     <= A;
                        r_b     <= B;
                        r_cnt   <= CW'(DIV_CYCLES);
                        r_state <= ST_BUSY;
                     end
                     OP_MTHI: r_hi <= A;
                     OP_MTLO: r_lo <= A;
                     default: ;
                  endcase
               end
            end
            ST_BUSY: begin
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  r_state <= ST_IDLE;
                  case (r_op)
                     OP_MULT, OP_MULTU: begin
                        r_hi <= w_prod[63:32];
                        r_lo <= w_prod[31:0];
                     end
                     OP_DIV, OP_DIVU: begin
                        // A zero divisor leaves HI/LO untouched
                        if (r_b != 32'd0) begin
                           r_hi <= w_rem;
                           r_lo <= w_quot;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_e_muldiv.sv
// Directed self-checking bench for e_muldiv (default MULT_CYCLES=5, DIV_CYCLES=10).
module tb_e_muldiv;

   logic        clk;
   logic        reset;
   logic        Req;
   logic [2:0]  mdOp;
   logic        rdSel;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] muldivRes_E;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   e_muldiv dut (
      .clk(clk), .reset(reset), .Req(Req), .mdOp(mdOp), .rdSel(rdSel),
      .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO), .muldivRes_E(muldivRes_E)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start an op, then count busy cycles after the accepting edge, optionally
   // injecting an opcode / Req during busy cycle inj_cycle.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int inj_cycle, input logic [2:0] inj_op, input logic inj_req,
                         input logic [31:0] inj_a, output int n, output logic early,
                         output logic start_busy);
      logic [31:0] hi0, lo0;
      mdOp = op; A = a; B = b; Req = 1'b0;
      #1;
      start_busy = busy;
      tick();
      mdOp = 3'd0; A = ~a; B = ~b;
      hi0 = HI; lo0 = LO; n = 0; early = 1'b0;
      while (busy && n < 40) begin
         if (n == inj_cycle) begin
            mdOp = inj_op; Req = inj_req; A = inj_a;
         end else if (n == inj_cycle + 1) begin
            mdOp = 3'd0;
         end
         tick();
         n++;
         if (busy && (HI !== hi0 || LO !== lo0)) early = 1'b1;
      end
      Req = 1'b0; mdOp = 3'd0;
   endtask

   task automatic test_reset();
      reset = 1'b0; Req = 1'b0; mdOp = 3'd0; rdSel = 1'b0; A = 32'hA5A5A5A5; B = 32'h5A5A5A5A;
      #12;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
      chk_cnt++; if (HI !== 32'd0) $display("FAIL reset_hi: got %h expected 00000000", HI); else pass_cnt++;
      chk_cnt++; if (LO !== 32'd0) $display("FAIL reset_lo: got %h expected 00000000", LO); else pass_cnt++;
      mdOp = 3'd1; #1;
      chk_cnt++; if (busy !== 1'b1) $display("FAIL reset_comb_busy: got %b expected 1", busy); else pass_cnt++;
      mdOp = 3'd0;
      @(posedge clk); #2; reset = 1'b1;
      tick();
   endtask

   task automatic test_mul(input logic [2:0] op, input string nm, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                           input int exp_n);
      int n; logic early, sb;
      run_op(op, a, b, -5, 3'd0, 1'b0, 32'd0, n, early, sb);
      chk_cnt++; if (sb !== 1'b1) $display("FAIL %s_start_busy: got %b expected 1", nm, sb); else pass_cnt++;
      chk_cnt++; if (n != exp_n) $display("FAIL %s_busy_cycles: got %0d expected %0d", nm, n, exp_n); else pass_cnt++;
      chk_cnt++; if (early !== 1'b0) $display("FAIL %s_early_write: got %b expected 0", nm, early); else pass_cnt++;
      chk_cnt++; if (HI !== exp_hi) $display("FAIL %s_hi: got %h expected %h", nm, HI, exp_hi); else pass_cnt++;
      chk_cnt++; if (LO !== exp_lo) $display("FAIL %s_lo: got %h expected %h", nm, LO, exp_lo); else pass_cnt++;
   endtask

   task automatic test_mthi_mtlo();
      mdOp = 3'd5; A = 32'h12345678; #1;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL mthi_busy: got %b expected 0", busy); else pass_cnt++;
      tick(); mdOp = 3'd0;
      chk_cnt++; if (HI !== 32'h12345678) $display("FAIL mthi_hi: got %h expected 12345678", HI); else pass_cnt++;
      rdSel = 1'b1; #1;
      chk_cnt++; if (muldivRes_E !== 32'h12345678) $display("FAIL mfhi: got %h expected 12345678", muldivRes_E); else pass_cnt++;
      mdOp = 3'd6; A = 32'hCAFEF00D; tick(); mdOp = 3'd0;
      rdSel = 1'b0; #1;
      chk_cnt++; if (muldivRes_E !== 32'hCAFEF00D) $display("FAIL mtlo_mflo: got %h expected cafef00d", muldivRes_E); else pass_cnt++;
      chk_cnt++; if (HI !== 32'h12345678) $display("FAIL mtlo_hi_kept: got %h expected 12345678", HI); else pass_cnt++;
   endtask

   task automatic test_req_flush();
      int n; logic early, sb;
      mdOp = 3'd1; Req = 1'b1; A = 32'd5; B = 32'd5; #1;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL flush_busy: got %b expected 0", busy); else pass_cnt++;
      tick(); mdOp = 3'd5; tick(); mdOp = 3'd0; Req = 1'b0; #1;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL flush_state: got %b expected 0", busy); else pass_cnt++;
      chk_cnt++; if (HI !== 32'h12345678 || LO !== 32'hCAFEF00D)
         $display("FAIL flush_hilo: got %h/%h expected 12345678/cafef00d", HI, LO); else pass_cnt++;
      // Req rising during an older DIV must not disturb it: 100/7 = 14 r 2
      run_op(3'd3, 32'd100, 32'd7, 2, 3'd0, 1'b1, 32'd0, n, early, sb);
      chk_cnt++; if (n != 10) $display("FAIL req_div_cycles: got %0d expected 10", n); else pass_cnt++;
      chk_cnt++; if (HI !== 32'd2 || LO !== 32'd14)
         $display("FAIL req_div_result: got %h/%h expected 00000002/0000000e", HI, LO); else pass_cnt++;
   endtask

   task automatic test_busy_ignore();
      int n; logic early, sb;
      // 6*7 = 42; MTLO injected on busy cycle 1, MULT on cycle 3
      run_op(3'd1, 32'd6, 32'd7, 1, 3'd6, 1'b0, 32'hDEADBEEF, n, early, sb);
      chk_cnt++; if (n != 5 || HI !== 32'd0 || LO !== 32'd42)
         $display("FAIL ignore_mtlo: got n=%0d %h/%h expected n=5 00000000/0000002a", n, HI, LO); else pass_cnt++;
      run_op(3'd2, 32'd9, 32'd9, 3, 3'd1, 1'b0, 32'hFFFFFFFF, n, early, sb);
      chk_cnt++; if (n != 5 || HI !== 32'd0 || LO !== 32'd81)
         $display("FAIL ignore_mult: got n=%0d %h/%h expected n=5 00000000/00000051", n, HI, LO); else pass_cnt++;
   endtask

   task automatic test_reset_abort();
      mdOp = 3'd3; A = 32'd100; B = 32'd7; tick(); mdOp = 3'd0;
      repeat (3) tick();
      #2 reset = 1'b0; #1;
      chk_cnt++; if (HI !== 32'd0 || LO !== 32'd0)
         $display("FAIL abort_clear: got %h/%h expected 00000000/00000000", HI, LO); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else pass_cnt++;
      @(posedge clk); #2 reset = 1'b1;
      repeat (12) tick();
      chk_cnt++; if (HI !== 32'd0 || LO !== 32'd0 || busy !== 1'b0)
         $display("FAIL abort_no_write: got %h/%h busy=%b expected 0/0 busy=0", HI, LO, busy); else pass_cnt++;
      mdOp = 3'd5; A = 32'h0BADF00D; tick(); mdOp = 3'd0;
      chk_cnt++; if (HI !== 32'h0BADF00D) $display("FAIL abort_idle_after: got %h expected 0badf00d", HI); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_mul(3'd1, "mult",  32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
      test_mul(3'd2, "multu", 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 5);
      test_mul(3'd3, "div",   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
      test_mul(3'd4, "divu0", 32'd7,        32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
      test_mul(3'd3, "divovf", 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10);
      test_mul(3'd4, "divu",  32'hFFFFFFF9, 32'd2, 32'h00000001, 32'h7FFFFFFC, 10);
      test_mthi_mtlo();
      test_req_flush();
      test_busy_ignore();
      test_reset_abort();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
